// File: rtl/sign_sum_scheduler.sv
// rtl/sign_sum_scheduler.sv - nibble-serial sign popcount with parity and majority flag
module popcount4 (
   input  logic [3:0] i_bits,
   output logic [2:0] o_sum
);
   always_comb begin
      o_sum = {2'b00, i_bits[0]} + {2'b00, i_bits[1]}
            + {2'b00, i_bits[2]} + {2'b00, i_bits[3]};
   end
endmodule

module sign_sum_scheduler #(
   parameter int DEG = 12
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [DEG-1:0]                i_sign,
   input  logic [$clog2(DEG+1)-1:0]      i_thr,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(DEG+1)-1:0]      o_count,
   output logic                          o_parity,
   output logic                          o_major,
   output logic                          o_busy
);
   localparam int NIB  = DEG / 4;
   localparam int CW   = $clog2(DEG + 1);
   localparam int CNTW = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [DEG-1:0] shreg_q, shreg_d;
   logic [CW-1:0]  thr_q, thr_d;
   logic [CW-1:0]  acc_q, acc_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]  count_q, count_d;
   logic           parity_q, parity_d;
   logic           major_q, major_d;
   logic           valid_q, valid_d;

   logic [2:0]     nib_sum;
   logic [CW-1:0]  acc_sum;

   popcount4 u_pop (
      .i_bits (shreg_q[3:0]),
      .o_sum  (nib_sum)
   );

   assign acc_sum = acc_q + CW'(nib_sum);

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      thr_d    = thr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      parity_d = parity_q;
      major_d  = major_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               shreg_d = i_sign;
               thr_d   = i_thr;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_sum;
            shreg_d = shreg_q >> 4;
            cnt_d   = cnt_q + 1'b1;
            // The last nibble's sum goes straight into the result registers.
            if (cnt_q == CNTW'(NIB - 1)) begin
               count_d  = acc_sum;
               parity_d = acc_sum[0];
               major_d  = (acc_sum >= thr_q);
               valid_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         thr_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         count_q  <= '0;
         parity_q <= 1'b0;
         major_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         thr_q    <= thr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         count_q  <= count_d;
         parity_q <= parity_d;
         major_q  <= major_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ready  = (state_q == IDLE);
   assign o_busy   = (state_q != IDLE);
   assign o_valid  = valid_q;
   assign o_count  = count_q;
   assign o_parity = parity_q;
   assign o_major  = major_q;
endmodule
